// File: rtl/program_sequencer.sv
// Program sequencer: fetches 12-bit words from a combinational ROM, issues one
// instruction per cycle to the ICU, and handles JMP/RTN through a small return stack.
package program_sequencer_pkg;
  typedef enum logic [3:0] {
    OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
    OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
    OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
    OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
  } instruction_t;
endpackage

module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [7:0]   mem_addr,
  input  logic [11:0]  mem_data,
  input  logic         jmp,
  input  logic         rtn,
  input  logic         flag_f,
  input  logic         resume,
  output instruction_t instr,
  output logic [7:0]   io_addr,
  output logic         halted,
  output logic         stk_err,
  output logic [3:0]   sp
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

  state_t       r_state, w_state;
  logic [7:0]   r_pc, w_pc;
  logic [7:0]   r_iss_pc, w_iss_pc;
  instruction_t r_instr, w_instr;
  logic [7:0]   r_io_addr, w_io_addr;
  logic [3:0]   r_sp, w_sp;
  logic         r_stk_err, w_stk_err;
  logic         w_push;
  logic [7:0]   r_stack [8];
  logic [2:0]   w_top_idx;

  assign w_top_idx = 3'(r_sp - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_pc      <= 8'h00;
      r_iss_pc  <= 8'h00;
      r_instr   <= OP_NOPO;
      r_io_addr <= 8'h00;
      r_sp      <= 4'd0;
      r_stk_err <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_iss_pc  <= w_iss_pc;
      r_instr   <= w_instr;
      r_io_addr <= w_io_addr;
      r_sp      <= w_sp;
      r_stk_err <= w_stk_err;
    end
  end

  // Stack contents are don't-care after reset, so they carry no reset term.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[2:0]] <= r_iss_pc + 8'd1;
  end

  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_iss_pc  = r_iss_pc;
    w_instr   = r_instr;
    w_io_addr = r_io_addr;
    w_sp      = r_sp;
    w_stk_err = r_stk_err;
    w_push    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (jmp) begin
          // Target is the operand of the JMP currently held in io_addr.
          w_pc      = r_io_addr;
          w_instr   = OP_NOPO;
          w_io_addr = 8'h00;
          if (r_sp < DEPTH) begin
            w_push = 1'b1;
            w_sp   = r_sp + 4'd1;
          end else begin
            w_stk_err = 1'b1;
          end
        end else if (rtn) begin
          w_instr   = OP_NOPO;
          w_io_addr = 8'h00;
          if (r_sp != 4'd0) begin
            w_pc = r_stack[w_top_idx];
            w_sp = r_sp - 4'd1;
          end else begin
            w_pc = r_pc + 8'd1;
          end
        end else if (flag_f) begin
          w_state   = S_HALT;
          w_instr   = OP_NOPO;
          w_io_addr = 8'h00;
        end else begin
          w_instr   = instruction_t'(mem_data[11:8]);
          w_io_addr = mem_data[7:0];
          w_iss_pc  = r_pc;
          w_pc      = r_pc + 8'd1;
        end
      end
      S_HALT: begin
        w_instr   = OP_NOPO;
        w_io_addr = 8'h00;
        if (resume) w_state = S_RUN;
      end
      default: w_state = S_RUN;
    endcase
  end

  assign mem_addr = r_pc;
  assign instr    = r_instr;
  assign io_addr  = r_io_addr;
  assign halted   = (r_state == S_HALT);
  assign stk_err  = r_stk_err;
  assign sp       = r_sp;

endmodule
